// File: rtl/port_wr_frontend.sv
// Per-port ingress stage: buffers one packet, requests an SRAM from the matcher,
// then streams the buffered packet tagged with the granted SRAM id.
//   state   | meaning
//   S_IDLE  | waiting for a header beat (wr_sop)
//   S_RECV  | storing payload beats; long-packet tail beats are dropped
//   S_WAIT  | packet complete, waiting for match_suc
//   S_DRAIN | streaming buffer[0..L] downstream
module port_wr_frontend #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_sop,
  input  logic              wr_eop,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [5:0]        new_length,
  output logic              match_enable,
  input  logic              match_suc,
  input  logic [5:0]        match_best_sram,
  output logic              out_vld,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic [4:0]        out_sram,
  output logic              len_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WAIT, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_q [DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [5:0]        len_q, len_d;
  logic              match_en_q, match_en_d;
  logic              match_done_q, match_done_d;
  logic [4:0]        sram_q, sram_d;
  logic              len_err_q, len_err_d;

  logic              wr_we;
  logic [AW-1:0]     wr_addr;
  logic              beat_acc;
  logic              match_hit;
  logic              match_ok;
  logic [CW-1:0]     len_beats;
  logic              unused_best_msb;

  assign unused_best_msb = match_best_sram[5];

  assign wr_ready     = (state_q == S_IDLE) || (state_q == S_RECV);
  assign beat_acc     = wr_vld && wr_ready;
  assign match_hit    = match_suc && match_en_q;
  assign match_ok     = match_done_q || match_hit;
  assign len_beats    = CW'(len_q) + CW'(1);

  assign new_length   = len_q;
  assign match_enable = match_en_q;
  assign out_sram     = sram_q;
  assign len_err      = len_err_q;
  assign out_vld      = (state_q == S_DRAIN);
  assign out_data     = buf_q[rd_ptr_q];
  assign out_sop      = out_vld && (rd_ptr_q == '0);
  assign out_eop      = out_vld && (rd_ptr_q == AW'(len_q));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_ptr_d     = rd_ptr_q;
    len_d        = len_q;
    match_en_d   = match_en_q;
    match_done_d = match_done_q;
    sram_d       = sram_q;
    len_err_d    = 1'b0;
    wr_we        = 1'b0;
    wr_addr      = cnt_q[AW-1:0];

    if (match_hit) begin
      match_en_d   = 1'b0;
      match_done_d = 1'b1;
      sram_d       = match_best_sram[4:0];
    end

    case (state_q)
      S_IDLE: begin
        if (beat_acc && wr_sop) begin
          wr_we      = 1'b1;
          wr_addr    = '0;
          len_d      = wr_data[15:10];
          match_en_d = 1'b1;
          cnt_d      = CW'(1);
          state_d    = (wr_eop && (wr_data[15:10] == 6'd0)) ? S_WAIT : S_RECV;
        end
      end
      S_RECV: begin
        if (beat_acc) begin
          // Count saturates at L+1 so surplus beats never overwrite the packet.
          if (cnt_q < len_beats) begin
            wr_we = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
          if (wr_eop) begin
            if ((cnt_q + CW'(1)) < len_beats) begin
              len_err_d    = 1'b1;
              match_en_d   = 1'b0;
              match_done_d = 1'b0;
              cnt_d        = '0;
              state_d      = S_IDLE;
            end else begin
              len_err_d = (cnt_q >= len_beats);
              state_d   = match_ok ? S_DRAIN : S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (match_ok) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (rd_ptr_q == AW'(len_q)) begin
            state_d      = S_IDLE;
            rd_ptr_d     = '0;
            cnt_d        = '0;
            match_done_d = 1'b0;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      match_en_q   <= 1'b0;
      match_done_q <= 1'b0;
      sram_q       <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      match_en_q   <= match_en_d;
      match_done_q <= match_done_d;
      sram_q       <= sram_d;
      len_err_q    <= len_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_we) buf_q[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_port_wr_frontend.sv
// Directed bench for port_wr_frontend: expected output beats are queued by the
// stimulus and checked by an independent monitor on the falling edge.
module tb_port_wr_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_sop, wr_eop, wr_vld;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [5:0]  new_length;
  logic        match_enable;
  logic        match_suc;
  logic [5:0]  match_best_sram;
  logic        out_vld, out_ready;
  logic [15:0] out_data;
  logic        out_sop, out_eop;
  logic [4:0]  out_sram;
  logic        len_err;

  port_wr_frontend #(.DATA_W(16), .DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld), .wr_data(wr_data),
    .wr_ready(wr_ready), .new_length(new_length), .match_enable(match_enable),
    .match_suc(match_suc), .match_best_sram(match_best_sram),
    .out_vld(out_vld), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop), .out_sram(out_sram), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        sop;
    logic        eop;
    logic [4:0]  sram;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected beat on every output handshake; checks hold while stalled.
  logic        stall_prev = 1'b0;
  logic [15:0] held_d;
  logic        held_sop, held_eop;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_vld) begin
        chk("stall_data", {16'd0, out_data}, {16'd0, held_d});
        chk("stall_sop_eop", {30'd0, out_sop, out_eop}, {30'd0, held_sop, held_eop});
      end
      if (out_vld && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {16'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", {16'd0, out_data}, {16'd0, e.d});
          chk("out_sop", {31'd0, out_sop}, {31'd0, e.sop});
          chk("out_eop", {31'd0, out_eop}, {31'd0, e.eop});
          chk("out_sram", {27'd0, out_sram}, {27'd0, e.sram});
        end
      end
      stall_prev = out_vld && !out_ready;
      held_d     = out_data;
      held_sop   = out_sop;
      held_eop   = out_eop;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] beat_data(input int L, input int base, input int i);
    logic [5:0] l6;
    logic [9:0] b10;
    l6  = 6'(L);
    b10 = 10'(base);
    return (i == 0) ? {l6, b10} : 16'(base + i);
  endfunction

  task automatic drive(input logic [15:0] d, input logic sop, input logic eop);
    wr_vld = 1'b1; wr_data = d; wr_sop = sop; wr_eop = eop;
    step();
    wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0;
  endtask

  task automatic send_pkt(input int L, input int n, input int base);
    for (int i = 0; i < n; i++) drive(beat_data(L, base, i), i == 0, i == n - 1);
  endtask

  task automatic push_exp(input int L, input int base, input int sram);
    for (int i = 0; i <= L; i++) begin
      exp_t e;
      e.d = beat_data(L, base, i); e.sop = (i == 0); e.eop = (i == L); e.sram = 5'(sram);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_match(input int best);
    match_suc = 1'b1; match_best_sram = 6'(best);
    step();
    match_suc = 1'b0; match_best_sram = 6'd0;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && wr_ready) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd1);
    chk({tag, "_match_enable"}, {31'd0, match_enable}, 32'd0);
    chk({tag, "_new_length"}, {26'd0, new_length}, 32'd0);
    chk({tag, "_outs"}, {28'd0, out_vld, out_sop, out_eop, len_err}, 32'd0);
    chk({tag, "_out_sram"}, {27'd0, out_sram}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_sop = 0; wr_eop = 0; wr_vld = 0; wr_data = 0;
    match_suc = 0; match_best_sram = 0; out_ready = 1'b1;
    #12;
    chk_reset_vals("reset");
    step(); step();
    rst = 1'b0;
    step();

    // 1: L=3, match_suc in cycle 5 with best=7
    push_exp(3, 16'h100, 7);
    wr_vld = 1; wr_sop = 1; wr_eop = 0; wr_data = beat_data(3, 16'h100, 0);
    chk("t1_men_c0", {31'd0, match_enable}, 32'd0);
    step();
    wr_sop = 0; wr_data = beat_data(3, 16'h100, 1);
    chk("t1_men_c1", {31'd0, match_enable}, 32'd1);
    chk("t1_new_length", {26'd0, new_length}, 32'd3);
    step();
    wr_data = beat_data(3, 16'h100, 2);
    step();
    wr_data = beat_data(3, 16'h100, 3); wr_eop = 1;
    step();
    wr_vld = 0; wr_eop = 0;
    chk("t1_wr_ready_wait", {31'd0, wr_ready}, 32'd0);
    chk("t1_out_vld_wait", {31'd0, out_vld}, 32'd0);
    step();
    match_suc = 1; match_best_sram = 6'd7;
    chk("t1_men_c5", {31'd0, match_enable}, 32'd1);
    step();
    match_suc = 0; match_best_sram = 0;
    chk("t1_men_c6", {31'd0, match_enable}, 32'd0);
    chk("t1_out_vld_c6", {31'd0, out_vld}, 32'd1);
    chk("t1_out_sram", {27'd0, out_sram}, 32'd7);
    step(); step(); step();
    chk("t1_wr_ready_c9", {31'd0, wr_ready}, 32'd0);
    step();
    chk("t1_wr_ready_c10", {31'd0, wr_ready}, 32'd1);
    chk("t1_all_beats", exp_q.size(), 32'd0);

    // 2: L=63, match_suc (best=12) mid-packet, drain right after eop
    push_exp(63, 16'h200, 12);
    fork
      send_pkt(63, 64, 16'h200);
      begin repeat (10) step(); pulse_match(12); end
    join
    chk("t2_out_vld_after_eop", {31'd0, out_vld}, 32'd1);
    chk("t2_out_sop_first", {31'd0, out_sop}, 32'd1);
    wait_done("t2_drain_done", 100);

    // 3: short packet L=10 with eop on beat 5
    send_pkt(10, 5, 16'h300);
    chk("t3_len_err", {31'd0, len_err}, 32'd1);
    chk("t3_men_drop", {31'd0, match_enable}, 32'd0);
    chk("t3_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("t3_out_vld", {31'd0, out_vld}, 32'd0);
    step();
    chk("t3_len_err_pulse", {31'd0, len_err}, 32'd0);
    chk("t3_out_vld_later", {31'd0, out_vld}, 32'd0);

    // 4: L=7 drained with out_ready toggling
    push_exp(7, 16'h400, 21);
    send_pkt(7, 8, 16'h400);
    out_ready = 1'b0;
    pulse_match(21);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      out_ready = ~out_ready;
      step();
    end
    out_ready = 1'b1;
    wait_done("t4_drain_done", 10);

    // Long packet: L=2 sent as 5 beats, 3 forwarded, len_err on eop
    push_exp(2, 16'h500, 5);
    send_pkt(2, 5, 16'h500);
    chk("tl_len_err", {31'd0, len_err}, 32'd1);
    chk("tl_wr_ready", {31'd0, wr_ready}, 32'd0);
    pulse_match(5);
    wait_done("tl_drain_done", 20);

    // 5: reset in RECV while match_enable=1
    drive(beat_data(9, 16'h600, 0), 1'b1, 1'b0);
    drive(beat_data(9, 16'h600, 1), 1'b0, 1'b0);
    drive(beat_data(9, 16'h600, 2), 1'b0, 1'b0);
    chk("t5_men_before", {31'd0, match_enable}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("t5_async");
    step(); step();
    rst = 1'b0;
    step();
    push_exp(2, 16'h700, 9);
    send_pkt(2, 3, 16'h700);
    pulse_match(9);
    wait_done("t5_next_pkt", 20);

    // 6: single-beat packet, best=33 so only the low five bits survive
    push_exp(0, 16'h080, 1);
    send_pkt(0, 1, 16'h080);
    chk("t6_new_length", {26'd0, new_length}, 32'd0);
    chk("t6_wr_ready", {31'd0, wr_ready}, 32'd0);
    pulse_match(33);
    chk("t6_out_vld", {31'd0, out_vld}, 32'd1);
    chk("t6_sop_eop", {30'd0, out_sop, out_eop}, 32'd3);
    wait_done("t6_drain_done", 10);

    step();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/port_wr_frontend.md
Name: port_wr_frontend

Overview:
- Per-port ingress stage sitting directly upstream of the per-port SRAM matcher.
- Buffers one incoming packet in a local 64-beat store and extracts its length from the header beat.
- Drives the matcher's match_enable/new_length handshake and latches the SRAM id returned on match_suc.
- Streams the buffered packet, tagged with the chosen SRAM, to the downstream SRAM write stage.

Parameters:
- DATA_W, 16, width of one packet beat (half-word).
- DEPTH, 64, buffer depth in beats; must be at least 64, the maximum packet size.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_sop  in  1  first beat of packet (header beat).
- wr_eop  in  1  last beat of packet.
- wr_vld  in  1  beat valid.
- wr_data  in  DATA_W  beat data.
- wr_ready  out  1  block can accept a beat.
- new_length  out  6  packet length field to matcher.
- match_enable  out  1  matcher request.
- match_suc  in  1  one-cycle matcher success pulse.
- match_best_sram  in  6  matcher result; valid in the match_suc cycle.
- out_vld  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  DATA_W  output beat.
- out_sop  out  1  first output beat.
- out_eop  out  1  last output beat.
- out_sram  out  5  target SRAM for the current packet.
- len_err  out  1  one-cycle pulse on length mismatch.

Behaviour:
- Reset values:
  - wr_ready=1; match_enable=0; new_length=0.
  - out_vld, out_sop, out_eop, len_err = 0; out_sram=0.
  - Buffer pointers and beat counter = 0; state=IDLE.
  - A reset asserted mid-packet discards the buffered packet and drops match_enable in the same cycle (asynchronous).
- Header format: L = wr_data[15:10]. Packet length = L+1 beats including the header.
- Beat acceptance: a beat is accepted when wr_vld && wr_ready.
- IDLE:
  - Beats without wr_sop are ignored.
  - Accepted beat with wr_sop: store at address 0, new_length<=L, match_enable<=1 from the next cycle, beat count=1.
  - If wr_eop is also set and L==0, go to WAIT; otherwise go to RECV.
- RECV:
  - Each accepted beat is stored at address = beat count; count increments.
  - eop with count+1 == L+1: go to WAIT; wr_ready goes to 0 the cycle after.
  - eop with count+1 < L+1 (short packet): pulse len_err, drop match_enable, clear buffer, go to IDLE without forwarding.
  - count reaches L+1 without eop (long packet): further beats are accepted but discarded until eop; len_err pulses on that eop; packet is forwarded with L+1 beats.
  - A wr_sop arriving in RECV is treated as an ordinary data beat.
- Match handshake:
  - match_enable is held high from the cycle after the header until the cycle after match_suc is sampled high, then driven 0.
  - In the match_suc cycle, out_sram <= match_best_sram[4:0] and match_done is set.
  - match_suc may arrive in RECV or WAIT; match_suc seen while match_enable=0 is ignored.
  - There is no timeout: the block waits indefinitely for a match.
- WAIT → DRAIN:
  - Enter DRAIN the cycle after both conditions hold: reception complete and match_done.
  - wr_ready=0 throughout WAIT and DRAIN.
- DRAIN:
  - out_vld=1; out_data = buffer[rd_ptr].
  - out_sop=1 when rd_ptr==0; out_eop=1 when rd_ptr==L.
  - rd_ptr advances on out_vld && out_ready; output holds stable while out_ready=0.
  - After the eop handshake: out_vld<=0, clear match_done and pointers, wr_ready<=1, state=IDLE.
  - Next-packet sop is accepted the cycle after the eop handshake at the earliest.
- Output latency: the first out_vld occurs 1 cycle after the later of the final input beat or match_suc.
- The buffer is a registered array; the read data path is combinational from rd_ptr.

Test Plan:
1. 4-beat packet (hdr L=3), match_suc at cycle 5 with best=7 → match_enable high cycles 1–5, out 4 beats with sop/eop, out_sram=7, wr_ready returns to 1 after eop handshake.
2. match_suc (best=12) arrives before eop of a 64-beat packet (L=63) → drain starts 1 cycle after eop, out_sram=12, all 64 beats in order.
3. Short packet: L=10, eop on beat 5 → len_err one pulse, match_enable drops, no out_vld, block ready next cycle.
4. out_ready toggled 1/0 every cycle during drain of an L=7 packet → every beat appears exactly once, data and out_sop/out_eop are stable while stalled.
5. rst asserted in RECV with match_enable=1 → match_enable, wr_ready and outputs return to reset values immediately; the next packet is processed normally.
6. Single-beat packet (sop+eop, L=0) → new_length=0, one out beat with out_sop=out_eop=1.
